sequence_detector: RTL

//   Receive-side counterpart of sequence_generator: samples a serial bit stream, converts it to parallel

---
 rtl/seq_pkg.sv | 14 +
 rtl/sipo_shift_register.sv | 40 ++++
 rtl/sequence_detector.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern generator/detector pair:
// frame-lock state encodings and the default pattern.
package seq_pkg;

  localparam int SEQ_LEN = 6;
  localparam logic [SEQ_LEN-1:0] SEQ_PATTERN = 6'b010011;

  typedef enum logic [2:0] {
    ST_HUNT   = 3'b001,
    ST_CHECK  = 3'b010,
    ST_LOCKED = 3'b100
  } state_t;

endpackage

// File: rtl/sipo_shift_register.sv
// Serial-in parallel-out shift register with a saturating fill counter,
// so the detector knows when a full LEN-bit window has been received.
module sipo_shift_register #(
  parameter int LEN = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           shift_en,
  input  logic           serial_in,
  output logic [LEN-1:0] q,
  output logic           full,
  output logic           almost_full
);

  localparam int FW = $clog2(LEN + 1);

  logic [LEN-1:0] r_q;
  logic [FW-1:0]  r_fill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q    <= '0;
      r_fill <= '0;
    end else if (clr) begin
      r_q    <= '0;
      r_fill <= '0;
    end else if (shift_en) begin
      r_q <= {r_q[LEN-2:0], serial_in};
      if (r_fill != FW'(LEN))
        r_fill <= r_fill + 1'b1;
    end
  end

  // almost_full lets the consumer see that the current beat completes the window
  assign q           = r_q;
  assign full        = (r_fill == FW'(LEN));
  assign almost_full = (r_fill == FW'(LEN - 1));

endmodule

// File: rtl/sequence_detector.sv
// Serial pattern detector with HUNT/CHECK/LOCKED frame-lock FSM and
// saturating match/error statistics. All outputs are registered.
module sequence_detector
  import seq_pkg::*;
#(
  parameter int             LEN     = SEQ_LEN,
  parameter logic [LEN-1:0] PATTERN = LEN'(SEQ_PATTERN),
  parameter int             LOCK_N  = 3,
  parameter int             MISS_N  = 2,
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             serial_in,
  input  logic             in_valid,
  input  logic             clr,
  output logic [LEN-1:0]   parallel_data_out,
  output logic             match,
  output logic             locked,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int PW = $clog2(LEN + 1);
  localparam int GW = $clog2(LOCK_N + 1);
  localparam int MW = $clog2(MISS_N + 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [LEN-1:0]   w_q;
  logic             w_full;
  logic             w_almost_full;
  logic [LEN-1:0]   w_shreg_next;
  logic             w_hit;
  logic [PW-1:0]    w_phase_inc;
  logic             w_boundary;
  logic [GW-1:0]    w_good_inc;
  logic [MW-1:0]    w_miss_inc;

  state_t           r_state;
  logic [PW-1:0]    r_phase;
  logic [GW-1:0]    r_good;
  logic [MW-1:0]    r_miss;
  logic             r_match;
  logic             r_locked;
  logic [CNT_W-1:0] r_match_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  sipo_shift_register #(.LEN(LEN)) u_sipo (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .shift_en    (in_valid),
    .serial_in   (serial_in),
    .q           (w_q),
    .full        (w_full),
    .almost_full (w_almost_full)
  );

  // Hit is evaluated on the window as it will look after this beat
  assign w_shreg_next = {w_q[LEN-2:0], serial_in};
  assign w_hit        = in_valid && (w_full || w_almost_full) && (w_shreg_next == PATTERN);
  assign w_phase_inc  = r_phase + 1'b1;
  assign w_boundary   = (w_phase_inc == PW'(LEN));
  assign w_good_inc   = r_good + 1'b1;
  assign w_miss_inc   = r_miss + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_HUNT;
      r_phase     <= '0;
      r_good      <= '0;
      r_miss      <= '0;
      r_match     <= 1'b0;
      r_locked    <= 1'b0;
      r_match_cnt <= '0;
      r_err_cnt   <= '0;
    end else if (clr) begin
      r_state     <= ST_HUNT;
      r_phase     <= '0;
      r_good      <= '0;
      r_miss      <= '0;
      r_match     <= 1'b0;
      r_locked    <= 1'b0;
      r_match_cnt <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_match <= w_hit;
      if (w_hit)
        r_match_cnt <= sat_inc(r_match_cnt);
      if (in_valid) begin
        unique case (r_state)
          ST_HUNT: begin
            if (w_hit) begin
              r_phase <= '0;
              r_good  <= GW'(1);
              if (LOCK_N == 1) begin
                r_state  <= ST_LOCKED;
                r_locked <= 1'b1;
                r_miss   <= '0;
              end else begin
                r_state <= ST_CHECK;
              end
            end
          end
          ST_CHECK: begin
            if (!w_boundary) begin
              r_phase <= w_phase_inc;
            end else if (w_hit) begin
              r_phase <= '0;
              r_good  <= w_good_inc;
              if (w_good_inc == GW'(LOCK_N)) begin
                r_state  <= ST_LOCKED;
                r_locked <= 1'b1;
                r_miss   <= '0;
              end
            end else begin
              r_state <= ST_HUNT;
              r_phase <= '0;
              r_good  <= '0;
            end
          end
          ST_LOCKED: begin
            // Off-boundary hits only pulse match; alignment stays on the locked phase
            if (!w_boundary) begin
              r_phase <= w_phase_inc;
            end else begin
              r_phase <= '0;
              if (w_hit) begin
                r_miss <= '0;
              end else begin
                r_miss    <= w_miss_inc;
                r_err_cnt <= sat_inc(r_err_cnt);
                if (w_miss_inc == MW'(MISS_N)) begin
                  r_state  <= ST_HUNT;
                  r_locked <= 1'b0;
                  r_good   <= '0;
                  r_miss   <= '0;
                end
              end
            end
          end
          default: begin
            r_state  <= ST_HUNT;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  assign parallel_data_out = w_q;
  assign match             = r_match;
  assign locked            = r_locked;
  assign match_cnt         = r_match_cnt;
  assign err_cnt           = r_err_cnt;

endmodule
